// File: rtl/control_pipe.sv
// control_pipe: main control for a 5-stage RV32I pipeline.
// Decodes the ID-stage opcode into a control bundle and carries it through the
// ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards
// and applies branch/jump flush and the global freeze, so the datapath only
// consumes staged controls.
module control_pipe #(
  parameter int RA_W      = 5,
  parameter bit UI_EN     = 1'b1,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            id_valid,
  input  logic [6:0]      id_opcode,
  input  logic [RA_W-1:0] id_rd,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            ex_flush,
  input  logic            freeze,
  output logic            hazard_stall,
  output logic            ex_valid,
  output logic            ex_branch,
  output logic            ex_add,
  output logic            ex_immediate,
  output logic            ex_illegal,
  output logic [1:0]      ex_jump,
  output logic [1:0]      ex_ui,
  output logic [RA_W-1:0] ex_rd,
  output logic            mem_valid,
  output logic            mem_memread,
  output logic            mem_memwrite,
  output logic [RA_W-1:0] mem_rd,
  output logic            wb_valid,
  output logic            wb_regwrite,
  output logic [1:0]      wb_toreg,
  output logic [RA_W-1:0] wb_rd
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Decoded ID-stage bundle
  logic       dec_branch;
  logic       dec_memread;
  logic       dec_memwrite;
  logic       dec_regwrite;
  logic       dec_immediate;
  logic       dec_add;
  logic       dec_illegal;
  logic [1:0] dec_jump;
  logic [1:0] dec_ui;
  logic [1:0] dec_toreg;
  logic       rs1_use;
  logic       rs2_use;

  // ID/EX control fields that are consumed internally, not exported
  logic       ex_memread;
  logic       ex_memwrite;
  logic       ex_regwrite;
  logic [1:0] ex_toreg;

  // EX/MEM control fields that are consumed internally, not exported
  logic       mem_regwrite;
  logic [1:0] mem_toreg;

  // Next-state value for the ID/EX register
  logic            load_bubble;
  logic            nx_valid;
  logic            nx_branch;
  logic            nx_add;
  logic            nx_immediate;
  logic            nx_illegal;
  logic [1:0]      nx_jump;
  logic [1:0]      nx_ui;
  logic [RA_W-1:0] nx_rd;
  logic            nx_memread;
  logic            nx_memwrite;
  logic            nx_regwrite;
  logic [1:0]      nx_toreg;

  // Opcode decode; unused fields stay 0, unknown opcodes only raise illegal
  always_comb begin
    dec_branch    = 1'b0;
    dec_memread   = 1'b0;
    dec_memwrite  = 1'b0;
    dec_regwrite  = 1'b0;
    dec_immediate = 1'b0;
    dec_add       = 1'b0;
    dec_illegal   = 1'b0;
    dec_jump      = 2'b00;
    dec_ui        = 2'b00;
    dec_toreg     = 2'd0;
    rs1_use       = 1'b0;
    rs2_use       = 1'b0;
    case (id_opcode)
      OP_R: begin
        dec_regwrite = 1'b1;
        rs1_use      = 1'b1;
        rs2_use      = 1'b1;
      end
      OP_IMM: begin
        dec_regwrite  = 1'b1;
        dec_immediate = 1'b1;
        rs1_use       = 1'b1;
      end
      OP_LOAD: begin
        dec_memread   = 1'b1;
        dec_toreg     = 2'd1;
        dec_add       = 1'b1;
        dec_regwrite  = 1'b1;
        dec_immediate = 1'b1;
        rs1_use       = 1'b1;
      end
      OP_STORE: begin
        dec_memwrite  = 1'b1;
        dec_add       = 1'b1;
        dec_immediate = 1'b1;
        rs1_use       = 1'b1;
        rs2_use       = 1'b1;
      end
      OP_BR: begin
        dec_branch = 1'b1;
        rs1_use    = 1'b1;
        rs2_use    = 1'b1;
      end
      OP_JAL: begin
        dec_jump     = 2'b01;
        dec_regwrite = 1'b1;
        dec_toreg    = 2'd2;
      end
      OP_JALR: begin
        dec_jump      = 2'b11;
        dec_regwrite  = 1'b1;
        dec_toreg     = 2'd2;
        dec_add       = 1'b1;
        dec_immediate = 1'b1;
        rs1_use       = 1'b1;
      end
      OP_LUI: begin
        if (UI_EN) begin
          dec_regwrite  = 1'b1;
          dec_immediate = 1'b1;
          dec_add       = 1'b1;
          dec_ui        = 2'b01;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_AUIPC: begin
        if (UI_EN) begin
          dec_regwrite  = 1'b1;
          dec_immediate = 1'b1;
          dec_add       = 1'b1;
          dec_ui        = 2'b10;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Load-use detection; a flushed ID instruction is dead so it never stalls
  always_comb begin
    if (HAZARD_EN && id_valid && ex_valid && ex_memread && (ex_rd != '0) && !ex_flush) begin
      hazard_stall = (rs1_use && (id_rs1 == ex_rd)) || (rs2_use && (id_rs2 == ex_rd));
    end else begin
      hazard_stall = 1'b0;
    end
  end

  // Select decoded bundle or a bubble for the ID/EX register
  always_comb begin
    load_bubble  = ex_flush || hazard_stall || !id_valid;
    nx_valid     = 1'b0;
    nx_branch    = 1'b0;
    nx_add       = 1'b0;
    nx_immediate = 1'b0;
    nx_illegal   = 1'b0;
    nx_jump      = 2'b00;
    nx_ui        = 2'b00;
    nx_rd        = '0;
    nx_memread   = 1'b0;
    nx_memwrite  = 1'b0;
    nx_regwrite  = 1'b0;
    nx_toreg     = 2'd0;
    if (load_bubble) begin
      nx_valid = 1'b0;
    end else begin
      nx_valid     = 1'b1;
      nx_branch    = dec_branch;
      nx_add       = dec_add;
      nx_immediate = dec_immediate;
      nx_illegal   = dec_illegal;
      nx_jump      = dec_jump;
      nx_ui        = dec_ui;
      nx_rd        = dec_regwrite ? id_rd : '0;
      nx_memread   = dec_memread;
      nx_memwrite  = dec_memwrite;
      nx_regwrite  = dec_regwrite;
      nx_toreg     = dec_toreg;
    end
  end

  // ID/EX control register; freeze holds it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_valid     <= 1'b0;
      ex_branch    <= 1'b0;
      ex_add       <= 1'b0;
      ex_immediate <= 1'b0;
      ex_illegal   <= 1'b0;
      ex_jump      <= 2'b00;
      ex_ui        <= 2'b00;
      ex_rd        <= '0;
      ex_memread   <= 1'b0;
      ex_memwrite  <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_toreg     <= 2'd0;
    end else if (!freeze) begin
      ex_valid     <= nx_valid;
      ex_branch    <= nx_branch;
      ex_add       <= nx_add;
      ex_immediate <= nx_immediate;
      ex_illegal   <= nx_illegal;
      ex_jump      <= nx_jump;
      ex_ui        <= nx_ui;
      ex_rd        <= nx_rd;
      ex_memread   <= nx_memread;
      ex_memwrite  <= nx_memwrite;
      ex_regwrite  <= nx_regwrite;
      ex_toreg     <= nx_toreg;
    end
  end

  // EX/MEM control register; passes the EX bundle on unless frozen
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_valid    <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_toreg    <= 2'd0;
      mem_rd       <= '0;
    end else if (!freeze) begin
      mem_valid    <= ex_valid;
      mem_memread  <= ex_memread;
      mem_memwrite <= ex_memwrite;
      mem_regwrite <= ex_regwrite;
      mem_toreg    <= ex_toreg;
      mem_rd       <= ex_rd;
    end
  end

  // MEM/WB control register; passes the MEM bundle on unless frozen
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_toreg    <= 2'd0;
      wb_rd       <= '0;
    end else if (!freeze) begin
      wb_valid    <= mem_valid;
      wb_regwrite <= mem_regwrite;
      wb_toreg    <= mem_toreg;
      wb_rd       <= mem_rd;
    end
  end

endmodule
